// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
//   Shared definitions for the gate-block BIST engine: FSM state encoding,
//   vector count, gate bit positions used in the mismatch mask and the
//   vector-index to stimulus mapping.
//   Ports: none (package).
package gate_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int NUM_VECTORS = 4;
   localparam int NUM_GATES   = 7;

   localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

   // Bit positions inside the 7-bit response / expected / mismatch vectors.
   localparam int GB_NOT  = 0;
   localparam int GB_AND  = 1;
   localparam int GB_NAND = 2;
   localparam int GB_OR   = 3;
   localparam int GB_NOR  = 4;
   localparam int GB_XOR  = 5;
   localparam int GB_XNOR = 6;

   // Vector order 0..3 is (a,b) = 00, 10, 01, 11: a is the index LSB.
   function automatic logic vec_a(input logic [1:0] idx);
      return idx[0];
   endfunction

   function automatic logic vec_b(input logic [1:0] idx);
      return idx[1];
   endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// gate_bist_ref
//   Combinational expected-value model of the basic gate block.
//   Ports:
//     a, b      : gate inputs
//     expected  : 7 expected gate outputs, bit order not/and/nand/or/nor/xor/xnor
module gate_bist_ref
   import gate_bist_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] expected
);

   always_comb begin
      expected          = '0;
      expected[GB_NOT]  = ~a;
      expected[GB_AND]  = a & b;
      expected[GB_NAND] = ~(a & b);
      expected[GB_OR]   = a | b;
      expected[GB_NOR]  = ~(a | b);
      expected[GB_XOR]  = a ^ b;
      expected[GB_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_bist.sv
// gate_bist
//   Built-in self-test engine for the basic gate block. Walks the four input
//   vectors, waits SETTLE_CYCLES after applying each, checks all seven gate
//   responses and reports pass, first failing vector, mismatch mask and the
//   number of failing vectors.
//   Optional feature: define GATE_BIST_ABORT_EN to stop at the first failing
//   vector instead of checking all four.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start               : begin a run (sampled only when idle)
//     in_a, in_b          : registered stimulus to the gate block
//     *_gate_out          : seven gate responses
//     busy, done          : run in progress / one-cycle end-of-run pulse
//     pass, fail_vec,
//     fail_mask, err_cnt  : results of the last run, held until next start
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 in_a,
   output logic                 in_b,
   input  logic                 not_gate_out,
   input  logic                 and_gate_out,
   input  logic                 nand_gate_out,
   input  logic                 or_gate_out,
   input  logic                 nor_gate_out,
   input  logic                 xor_gate_out,
   input  logic                 xnor_gate_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [1:0]           fail_vec,
   output logic [NUM_GATES-1:0] fail_mask,
   output logic [2:0]           err_cnt
);

   // Settle counter runs 0..SETTLE_CYCLES-1; it is never entered when
   // SETTLE_CYCLES is 0, so a minimal 1-bit counter is kept in that case.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   state_e               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 in_a_q, in_a_d;
   logic                 in_b_q, in_b_d;
   logic                 pass_q, pass_d;
   logic [1:0]           fail_vec_q, fail_vec_d;
   logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
   logic [2:0]           err_cnt_q, err_cnt_d;

   logic [NUM_GATES-1:0] resp;
   logic [NUM_GATES-1:0] expected;
   logic [NUM_GATES-1:0] mismatch;
   logic                 any_mis;
   logic                 abort_now;

   always_comb begin
      resp          = '0;
      resp[GB_NOT]  = not_gate_out;
      resp[GB_AND]  = and_gate_out;
      resp[GB_NAND] = nand_gate_out;
      resp[GB_OR]   = or_gate_out;
      resp[GB_NOR]  = nor_gate_out;
      resp[GB_XOR]  = xor_gate_out;
      resp[GB_XNOR] = xnor_gate_out;
   end

   // Expected values follow the stimulus actually being driven.
   gate_bist_ref u_ref (
      .a        (in_a_q),
      .b        (in_b_q),
      .expected (expected)
   );

   for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_mis
      assign mismatch[gi] = resp[gi] ^ expected[gi];
   end

   assign any_mis = |mismatch;

`ifdef GATE_BIST_ABORT_EN
   assign abort_now = any_mis;
`else
   assign abort_now = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      in_a_d      = in_a_q;
      in_b_d      = in_b_q;
      pass_d      = pass_q;
      fail_vec_d  = fail_vec_q;
      fail_mask_d = fail_mask_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_APPLY;
               idx_d       = '0;
               pass_d      = 1'b0;
               fail_vec_d  = '0;
               fail_mask_d = '0;
               err_cnt_d   = '0;
            end
         end

         ST_APPLY: begin
            in_a_d  = vec_a(idx_q);
            in_b_d  = vec_b(idx_q);
            cnt_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_CHECK: begin
            if (any_mis) begin
               fail_mask_d = fail_mask_q | mismatch;
               err_cnt_d   = err_cnt_q + 3'd1;
               // No earlier failing vector in this run yet.
               if (err_cnt_q == 3'd0) begin
                  fail_vec_d = idx_q;
               end
            end
            if ((idx_q == LAST_VEC) || abort_now) begin
               // Pass is resolved on entry to DONE so it is valid with done.
               state_d = ST_DONE;
               pass_d  = (err_cnt_q == 3'd0) && !any_mis;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_APPLY;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         in_a_q      <= 1'b0;
         in_b_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_vec_q  <= '0;
         fail_mask_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         in_a_q      <= in_a_d;
         in_b_q      <= in_b_d;
         pass_q      <= pass_d;
         fail_vec_q  <= fail_vec_d;
         fail_mask_q <= fail_mask_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign in_a      = in_a_q;
   assign in_b      = in_b_q;
   assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                      (state_q == ST_CHECK);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign fail_vec  = fail_vec_q;
   assign fail_mask = fail_mask_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist
//   Scoreboard bench for gate_bist. Two instances run side by side
//   (SETTLE_CYCLES = 4 and 0), each wired to its own behavioural gate block
//   with injectable faults (stuck-at-0/1 masks, nand/nor swap). Every accepted
//   start pushes a predicted result computed from the gate truth rules; a
//   monitor pops and compares on each done pulse and checks busy every cycle.
//   Honours GATE_BIST_ABORT_EN in its prediction.
module tb_gate_bist;

`ifdef GATE_BIST_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   typedef struct packed {
      logic [6:0] sa0;
      logic [6:0] sa1;
      logic       swap;
   } fault_t;

   typedef struct {
      int       start_cyc;
      int       done_cyc;
      bit       pass;
      bit [1:0] fv;
      bit [6:0] mask;
      int       err;
      bit       last_a;
      bit       last_b;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic       start_s     [2];
   logic       in_a_s      [2];
   logic       in_b_s      [2];
   logic [6:0] resp_s      [2];
   logic       busy_s      [2];
   logic       done_s      [2];
   logic       pass_s      [2];
   logic [1:0] fail_vec_s  [2];
   logic [6:0] fail_mask_s [2];
   logic [2:0] err_cnt_s   [2];
   fault_t     fault_s     [2];

   sb_t sbq [2][$];
   int  edge_cnt = 0;
   int  vectors = 0;
   int  miscompares = 0;

   function automatic int settle_of(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   // Truth table from arithmetic on 0/1 integers.
   function automatic logic [6:0] truth(input int a, input int b);
      logic [6:0] t;
      t[0] = (a == 0);
      t[1] = (a * b == 1);
      t[2] = (a * b == 0);
      t[3] = (a + b >= 1);
      t[4] = (a + b == 0);
      t[5] = (a + b == 1);
      t[6] = (a + b != 1);
      return t;
   endfunction

   // Behavioural gate block, possibly faulty.
   function automatic logic [6:0] gate_block(input int a, input int b, input fault_t f);
      logic [6:0] g;
      logic       tmp;
      g = truth(a, b);
      if (f.swap) begin
         tmp  = g[2];
         g[2] = g[4];
         g[4] = tmp;
      end
      return (g & ~f.sa0) | f.sa1;
   endfunction

   function automatic sb_t predict(input fault_t f, input int s, input int n);
      sb_t        e;
      logic [6:0] mis;
      int         last;
      bit         stopped;
      e.start_cyc = n;
      e.fv        = 2'd0;
      e.mask      = 7'd0;
      e.err       = 0;
      last        = 3;
      stopped     = 1'b0;
      for (int v = 0; v < 4; v++) begin
         if (!stopped) begin
            mis = truth(v % 2, v / 2) ^ gate_block(v % 2, v / 2, f);
            if (mis != 7'd0) begin
               if (e.err == 0) e.fv = v[1:0];
               e.err++;
               e.mask |= mis;
               if (ABORT) begin
                  last    = v;
                  stopped = 1'b1;
               end
            end
         end
      end
      e.pass     = (e.err == 0);
      e.done_cyc = n + (last + 1) * (s + 2) + 1;
      e.last_a   = (last % 2) == 1;
      e.last_b   = (last / 2) == 1;
      return e;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      gate_bist #(.SETTLE_CYCLES(gi == 0 ? 4 : 0)) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .start         (start_s[gi]),
         .in_a          (in_a_s[gi]),
         .in_b          (in_b_s[gi]),
         .not_gate_out  (resp_s[gi][0]),
         .and_gate_out  (resp_s[gi][1]),
         .nand_gate_out (resp_s[gi][2]),
         .or_gate_out   (resp_s[gi][3]),
         .nor_gate_out  (resp_s[gi][4]),
         .xor_gate_out  (resp_s[gi][5]),
         .xnor_gate_out (resp_s[gi][6]),
         .busy          (busy_s[gi]),
         .done          (done_s[gi]),
         .pass          (pass_s[gi]),
         .fail_vec      (fail_vec_s[gi]),
         .fail_mask     (fail_mask_s[gi]),
         .err_cnt       (err_cnt_s[gi])
      );
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         resp_s[k] = gate_block(int'(in_a_s[k]), int'(in_b_s[k]), fault_s[k]);
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, edge_cnt, act, exp);
      end
   endtask

   // Monitor: at each falling edge (cycle number == edge_cnt) compare outputs.
   always @(negedge clk) begin
      sb_t e;
      bit  exp_busy;
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (done_s[k]) begin
               if (sbq[k].size() == 0) begin
                  chk("unexpected_done", k, 32'd1, 32'd0);
               end else begin
                  e = sbq[k].pop_front();
                  chk("done_cycle", k, 32'(edge_cnt), 32'(e.done_cyc));
                  chk("pass", k, 32'(pass_s[k]), 32'(e.pass));
                  chk("fail_vec", k, 32'(fail_vec_s[k]), 32'(e.fv));
                  chk("fail_mask", k, 32'(fail_mask_s[k]), 32'(e.mask));
                  chk("err_cnt", k, 32'(err_cnt_s[k]), 32'(e.err));
                  chk("busy_in_done", k, 32'(busy_s[k]), 32'd0);
                  chk("in_a_hold", k, 32'(in_a_s[k]), 32'(e.last_a));
                  chk("in_b_hold", k, 32'(in_b_s[k]), 32'(e.last_b));
                  $display("run dut%0d start %0d done %0d pass=%0d fail_vec=%0d mask=%07b err=%0d",
                           k, e.start_cyc, edge_cnt, pass_s[k], fail_vec_s[k],
                           fail_mask_s[k], err_cnt_s[k]);
               end
            end else begin
               exp_busy = (sbq[k].size() != 0) && (edge_cnt > sbq[k][0].start_cyc) &&
                          (edge_cnt < sbq[k][0].done_cyc);
               chk("busy", k, 32'(busy_s[k]), 32'(exp_busy));
            end
         end
      end
   end

   task automatic check_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_a", k, 32'(in_a_s[k]), 32'd0);
         chk("rst_in_b", k, 32'(in_b_s[k]), 32'd0);
         chk("rst_busy", k, 32'(busy_s[k]), 32'd0);
         chk("rst_done", k, 32'(done_s[k]), 32'd0);
         chk("rst_pass", k, 32'(pass_s[k]), 32'd0);
         chk("rst_fail_vec", k, 32'(fail_vec_s[k]), 32'd0);
         chk("rst_fail_mask", k, 32'(fail_mask_s[k]), 32'd0);
         chk("rst_err_cnt", k, 32'(err_cnt_s[k]), 32'd0);
      end
   endtask

   task automatic launch(input bit en0, input fault_t f0, input bit en1, input fault_t f1);
      @(negedge clk);
      fault_s[0] = f0;
      fault_s[1] = f1;
      if (en0) begin
         start_s[0] = 1'b1;
         sbq[0].push_back(predict(f0, settle_of(0), edge_cnt));
      end
      if (en1) begin
         start_s[1] = 1'b1;
         sbq[1].push_back(predict(f1, settle_of(1), edge_cnt));
      end
      @(negedge clk);
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (t < 300 && (sbq[0].size() != 0 || sbq[1].size() != 0)) begin
         @(negedge clk);
         t++;
      end
      if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
         chk("done_timeout", 0, 32'(sbq[0].size() + sbq[1].size()), 32'd0);
         sbq[0].delete();
         sbq[1].delete();
      end
   endtask

   function automatic fault_t rand_fault();
      fault_t f;
      f = '0;
      case ($urandom_range(0, 3))
         0: f = '0;
         1: f.sa0 = 7'(1 << $urandom_range(0, 6));
         2: f.sa1 = 7'($urandom & 32'h7f);
         default: begin
            f.swap = 1'b1;
            f.sa0  = 7'($urandom & $urandom & 32'h7f);
         end
      endcase
      return f;
   endfunction

   initial begin
      fault_t nf, f_xor0, f_and1, f_swap;
      int     n;
      nf     = '0;
      f_xor0 = '0; f_xor0.sa0 = 7'b0100000;
      f_and1 = '0; f_and1.sa1 = 7'b0000010;
      f_swap = '0; f_swap.swap = 1'b1;

      rst_n      = 1'b1;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      fault_s[0] = '0;
      fault_s[1] = '0;
      #1 rst_n = 1'b0;
      #1 check_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Clean gate blocks, then the directed fault cases.
      launch(1'b1, nf, 1'b1, nf);         drain();
      launch(1'b1, f_xor0, 1'b1, f_and1); drain();
      launch(1'b1, f_swap, 1'b1, f_xor0); drain();
      launch(1'b1, f_and1, 1'b1, f_swap); drain();

      // start re-pulsed during a run and in the DONE cycle is ignored.
      @(negedge clk);
      n = edge_cnt;
      fault_s[0] = nf;
      start_s[0] = 1'b1;
      sbq[0].push_back(predict(nf, settle_of(0), n));
      @(negedge clk); start_s[0] = 1'b0;
      while (edge_cnt < n + 5) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      while (edge_cnt < n + 25) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      while (edge_cnt < n + 27) @(negedge clk);
      start_s[0] = 1'b1;
      sbq[0].push_back(predict(nf, settle_of(0), edge_cnt));
      @(negedge clk); start_s[0] = 1'b0;
      drain();

      // Randomized faults and start patterns.
      for (int i = 0; i < 24; i++) begin
         launch(($urandom_range(0, 3) != 0), rand_fault(),
                ($urandom_range(0, 3) != 0), rand_fault());
         drain();
      end

      // Leave non-zero results, then reset in the middle of a run.
      launch(1'b1, f_xor0, 1'b1, f_swap); drain();
      launch(1'b1, f_xor0, 1'b1, f_and1);
      n = sbq[0][0].start_cyc;
      while (edge_cnt < n + 10) @(negedge clk);
      #2 rst_n = 1'b0;
      sbq[0].delete();
      sbq[1].delete();
      #1 check_reset();
      @(negedge clk);
      rst_n = 1'b1;
      launch(1'b1, nf, 1'b1, nf); drain();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
